pam_demodulator: RTL and testbench
==================================

PAM_DEMODULATOR -- requirements
Module: pam_demodulator

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 24: bits per frame, MSB first, minimum 16.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer flops on each serial input, minimum 2.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1 bit: when low, the block holds IDLE and issues no writes.
REQ-006 SHALL have port bclk, input, 1 bit: asynchronous serial bit clock.
REQ-007 SHALL have port nsync, input, 1 bit: asynchronous frame sync, active low.
REQ-008 SHALL have port sdata, input, 1 bit: asynchronous serial data.
REQ-009 SHALL have port word, output, DATA_LENGTH bits: last complete frame.
REQ-010 SHALL have port word_valid, output, 1 bit: one-cycle pulse when word updates.
REQ-011 SHALL have port wdata, output, 8 bits: FIFO write data.
REQ-012 SHALL have port write, output, 1 bit: FIFO write strobe, one cycle per byte.
REQ-013 SHALL have port full, input, 1 bit: FIFO full.
REQ-014 SHALL have port frame_error, output, 1 bit: one-cycle pulse on an aborted frame.
REQ-015 SHALL have port overflow, output, 1 bit: sticky flag set on a dropped byte.
REQ-016 SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-017 SHALL pass bclk, nsync and sdata each through SYNC_STAGES flops, then detect edges from the last stage against a one-cycle-delayed copy.
REQ-018 SHALL implement the states IDLE, SHIFT, WR0, WR1 and WAIT_END.
REQ-019 IDLE SHALL move to SHIFT only on a synchronized nsync falling edge with enable high, clearing the bit count and shift register.
REQ-020 A low nsync already present at reset release SHALL NOT start a frame.
REQ-021 SHIFT SHALL shift the synchronized sdata in at the LSB on each synchronized bclk falling edge and increment the bit count.
REQ-022 When the DATA_LENGTH-th bit is captured, on that same edge the block SHALL load word, pulse word_valid and enter WR0.
REQ-023 Word latency SHALL be SYNC_STAGES+1 clk cycles from the first clk edge that samples the raw bclk low.
REQ-024 If synchronized nsync rises in SHIFT before the count completes, the block SHALL pulse frame_error, discard the bits, leave word unchanged and return to IDLE.
REQ-025 WR0, in the cycle after word_valid, SHALL assert write with wdata=word[7:0] if full=0 and go to WR1; if full=1 it SHALL set overflow, write nothing and go to WAIT_END.
REQ-026 WR1 SHALL assert write with wdata=word[15:8] if full=0, or set overflow and write nothing if full=1, and then go to WAIT_END.
REQ-027 A frame SHALL yield at most 2 writes, never word[15:8] without word[7:0], and those writes SHALL be in the two cycles following word_valid.
REQ-028 WAIT_END SHALL ignore further bclk edges and return to IDLE when synchronized nsync is high.
REQ-029 wdata SHALL hold its last value when write=0.
REQ-030 overflow SHALL clear only on rst.
REQ-031 enable going low in any state SHALL force IDLE next cycle, suppressing pending writes; word and overflow SHALL be held.
REQ-032 Correct operation SHALL require bclk high and low phases of at least SYNC_STAGES+1 clk cycles each, which 12 clk per bclk satisfies.

Reset
REQ-033 On rst, state SHALL be IDLE.
REQ-034 On rst, word, wdata, the bit count and the shift register SHALL be 0.
REQ-035 On rst, word_valid, write, frame_error, overflow and busy SHALL be 0.
REQ-036 A rst mid-frame SHALL discard the partial frame and wait for a fresh nsync falling edge.

Verification
REQ-037 Bench SHALL check a good frame: 24 bits 0x00A55A, 12 clk/bclk, full=0 -> word=0x00A55A, one word_valid, then write wdata=0x5A, then write wdata=0xA5 in consecutive cycles.
REQ-038 Bench SHALL check an aborted frame: nsync high after 10 bits -> frame_error pulse, no write, word unchanged; the next good frame 0x001234 -> writes 0x34, 0x12.
REQ-039 Bench SHALL check FIFO full: full=1 during WR0 -> overflow=1, zero writes that frame; overflow stays 1 through a later good frame until rst.
REQ-040 Bench SHALL check full rising during WR1: write 0x5A only, overflow=1, then IDLE after nsync high.
REQ-041 Bench SHALL check reset mid-frame: rst after 8 bits, then the frame continues -> no word_valid; the next complete frame is received correctly.
REQ-042 Bench SHALL check extra bits and start-up: 30 bclk falls within one nsync low -> word holds the first 24 bits and exactly 2 writes occur; nsync held low at reset release -> no frame.

Source files
------------

// File: rtl/pam_demodulator.sv
// PAM serial frame demodulator.
// Receives MSB-first frames clocked by an asynchronous bit clock and framed by an
// active-low sync, presents each complete frame on word, and pushes the low two
// bytes into a downstream FIFO with overflow tracking.
module pam_demodulator #(
    parameter int DATA_LENGTH = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   bclk,
    input  logic                   nsync,
    input  logic                   sdata,
    output logic [DATA_LENGTH-1:0] word,
    output logic                   word_valid,
    output logic [7:0]             wdata,
    output logic                   write,
    input  logic                   full,
    output logic                   frame_error,
    output logic                   overflow,
    output logic                   busy
);

    localparam int COUNT_WIDTH = $clog2(DATA_LENGTH);
    localparam logic [COUNT_WIDTH-1:0] LAST_BIT = COUNT_WIDTH'(DATA_LENGTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        WR0,
        WR1,
        WAIT_END
    } state_t;

    logic [SYNC_STAGES-1:0] r_bclkSync;
    logic [SYNC_STAGES-1:0] r_nsyncSync;
    logic [SYNC_STAGES-1:0] r_sdataSync;
    logic                   r_bclkPrev;
    logic                   r_nsyncPrev;

    state_t                 r_state;
    logic [COUNT_WIDTH-1:0] r_bitCount;
    logic [DATA_LENGTH-1:0] r_shiftReg;
    logic [DATA_LENGTH-1:0] r_word;
    logic                   r_wordValid;
    logic [7:0]             r_wdata;
    logic                   r_write;
    logic                   r_frameError;
    logic                   r_overflow;
    logic                   r_busy;

    logic w_bclkFall;
    logic w_nsyncFall;
    logic w_nsyncRise;
    logic w_nsyncLevel;
    logic w_sdataBit;

    // Synchronizer chains plus one delayed copy of bclk/nsync for edge detection.
    // Everything clears to 0 so a sync line already low at reset release never
    // looks like a falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bclkSync  <= '0;
            r_nsyncSync <= '0;
            r_sdataSync <= '0;
            r_bclkPrev  <= 1'b0;
            r_nsyncPrev <= 1'b0;
        end else begin
            r_bclkSync  <= {r_bclkSync[SYNC_STAGES-2:0], bclk};
            r_nsyncSync <= {r_nsyncSync[SYNC_STAGES-2:0], nsync};
            r_sdataSync <= {r_sdataSync[SYNC_STAGES-2:0], sdata};
            r_bclkPrev  <= r_bclkSync[SYNC_STAGES-1];
            r_nsyncPrev <= r_nsyncSync[SYNC_STAGES-1];
        end
    end

    assign w_bclkFall   = r_bclkPrev & ~r_bclkSync[SYNC_STAGES-1];
    assign w_nsyncFall  = r_nsyncPrev & ~r_nsyncSync[SYNC_STAGES-1];
    assign w_nsyncRise  = ~r_nsyncPrev & r_nsyncSync[SYNC_STAGES-1];
    assign w_nsyncLevel = r_nsyncSync[SYNC_STAGES-1];
    assign w_sdataBit   = r_sdataSync[SYNC_STAGES-1];

    // Frame FSM: shift bits in, publish the word, then issue up to two FIFO writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bitCount   <= '0;
            r_shiftReg   <= '0;
            r_word       <= '0;
            r_wordValid  <= 1'b0;
            r_wdata      <= '0;
            r_write      <= 1'b0;
            r_frameError <= 1'b0;
            r_overflow   <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_wordValid  <= 1'b0;
            r_write      <= 1'b0;
            r_frameError <= 1'b0;
            if (!enable) begin
                r_state <= IDLE;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_nsyncFall) begin
                            r_state    <= SHIFT;
                            r_bitCount <= '0;
                            r_shiftReg <= '0;
                            r_busy     <= 1'b1;
                        end
                    end
                    SHIFT: begin
                        if (w_nsyncRise) begin
                            r_frameError <= 1'b1;
                            r_bitCount   <= '0;
                            r_shiftReg   <= '0;
                            r_state      <= IDLE;
                            r_busy       <= 1'b0;
                        end else if (w_bclkFall) begin
                            r_shiftReg <= {r_shiftReg[DATA_LENGTH-2:0], w_sdataBit};
                            r_bitCount <= r_bitCount + COUNT_WIDTH'(1);
                            if (r_bitCount == LAST_BIT) begin
                                r_word      <= {r_shiftReg[DATA_LENGTH-2:0], w_sdataBit};
                                r_wordValid <= 1'b1;
                                r_state     <= WR0;
                            end
                        end
                    end
                    WR0: begin
                        if (full) begin
                            r_overflow <= 1'b1;
                            r_state    <= WAIT_END;
                        end else begin
                            r_write <= 1'b1;
                            r_wdata <= r_word[7:0];
                            r_state <= WR1;
                        end
                    end
                    WR1: begin
                        if (full) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_write <= 1'b1;
                            r_wdata <= r_word[15:8];
                        end
                        r_state <= WAIT_END;
                    end
                    WAIT_END: begin
                        if (w_nsyncLevel) begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign word        = r_word;
    assign word_valid  = r_wordValid;
    assign wdata       = r_wdata;
    assign write       = r_write;
    assign frame_error = r_frameError;
    assign overflow    = r_overflow;
    assign busy        = r_busy;

endmodule

// File: tb/tb_pam_demodulator.sv
// Directed bench for pam_demodulator: a table of frames with hand-computed
// results followed by hand-written reset, start-up and enable sequences.
module tb_pam_demodulator;

    localparam int DATA_LENGTH = 24;
    localparam int SYNC_STAGES = 2;
    localparam int NUM_VECS    = 7;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   enable = 1'b1;
    logic                   bclk = 1'b1;
    logic                   nsync = 1'b1;
    logic                   sdata = 1'b0;
    logic                   full = 1'b0;
    logic [DATA_LENGTH-1:0] word;
    logic                   word_valid;
    logic [7:0]             wdata;
    logic                   write;
    logic                   frame_error;
    logic                   overflow;
    logic                   busy;

    typedef struct {
        logic [31:0] data;
        int          nbits;
        int          abortAfter;
        bit          fullAll;
        bit          fullWr1;
        logic [23:0] expWord;
        int          expValid;
        int          expWrites;
        logic [7:0]  expByte0;
        logic [7:0]  expByte1;
        int          expFe;
        bit          expOvf;
    } vec_t;

    vec_t vecs[NUM_VECS];

    int passCount = 0;
    int checkCount = 0;
    int lastFallCycle = 0;

    int         cycle = 0;
    int         wvCount = 0;
    int         wvCycle = 0;
    int         wrCount = 0;
    int         feCount = 0;
    logic [7:0] wrData[64];
    int         wrCycle[64];

    pam_demodulator #(
        .DATA_LENGTH(DATA_LENGTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .bclk       (bclk),
        .nsync      (nsync),
        .sdata      (sdata),
        .word       (word),
        .word_valid (word_valid),
        .wdata      (wdata),
        .write      (write),
        .full       (full),
        .frame_error(frame_error),
        .overflow   (overflow),
        .busy       (busy)
    );

    // Free-running system clock.
    always #5 clk = ~clk;

    // Cycle counter used to time word_valid and write pulses.
    always @(posedge clk) cycle <= cycle + 1;

    // Monitor that logs every word_valid, write and frame_error pulse.
    always @(negedge clk) begin
        if (word_valid) begin
            wvCount <= wvCount + 1;
            wvCycle <= cycle;
        end
        if (write && wrCount < 64) begin
            wrData[wrCount]  <= wdata;
            wrCycle[wrCount] <= cycle;
            wrCount          <= wrCount + 1;
        end
        if (frame_error) feCount <= feCount + 1;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic sendBits(input logic [31:0] data, input int nbits, input int abortAfter, input bit fullWr1);
        for (int i = 0; i < nbits; i++) begin
            if (abortAfter != 0 && i == abortAfter) break;
            sdata = data[nbits-1-i];
            repeat (6) @(negedge clk);
            bclk = 1'b0;
            if (i == DATA_LENGTH - 1) lastFallCycle = cycle;
            if (fullWr1 && i == DATA_LENGTH - 1) begin
                repeat (4) @(negedge clk);
                full = 1'b1;
                repeat (2) @(negedge clk);
            end else begin
                repeat (6) @(negedge clk);
            end
            bclk = 1'b1;
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        full = v.fullAll;
        nsync = 1'b0;
        repeat (8) @(negedge clk);
        sendBits(v.data, v.nbits, v.abortAfter, v.fullWr1);
        repeat (6) @(negedge clk);
        nsync = 1'b1;
        repeat (10) @(negedge clk);
        full = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic checkVector(input string label, input vec_t v, input int wv0, input int wr0, input int fe0);
        checkOutput({label, " word"}, 32'(word), 32'(v.expWord));
        checkOutput({label, " word_valid count"}, 32'(wvCount - wv0), 32'(v.expValid));
        checkOutput({label, " write count"}, 32'(wrCount - wr0), 32'(v.expWrites));
        checkOutput({label, " frame_error count"}, 32'(feCount - fe0), 32'(v.expFe));
        checkOutput({label, " overflow"}, 32'(overflow), 32'(v.expOvf));
        checkOutput({label, " busy after frame"}, 32'(busy), 32'(0));
        if (v.expValid == 1)
            checkOutput({label, " word latency"}, 32'(wvCycle), 32'(lastFallCycle + SYNC_STAGES + 1));
        if (v.expWrites >= 1 && wr0 < 63) begin
            checkOutput({label, " byte0"}, 32'(wrData[wr0]), 32'(v.expByte0));
            checkOutput({label, " byte0 timing"}, 32'(wrCycle[wr0]), 32'(wvCycle + 1));
        end
        if (v.expWrites >= 2 && wr0 < 62) begin
            checkOutput({label, " byte1"}, 32'(wrData[wr0+1]), 32'(v.expByte1));
            checkOutput({label, " byte1 timing"}, 32'(wrCycle[wr0+1]), 32'(wvCycle + 2));
        end
    endtask

    task automatic checkResetState(input string label);
        checkOutput({label, " word"}, 32'(word), 32'(0));
        checkOutput({label, " word_valid"}, 32'(word_valid), 32'(0));
        checkOutput({label, " wdata"}, 32'(wdata), 32'(0));
        checkOutput({label, " write"}, 32'(write), 32'(0));
        checkOutput({label, " frame_error"}, 32'(frame_error), 32'(0));
        checkOutput({label, " overflow"}, 32'(overflow), 32'(0));
        checkOutput({label, " busy"}, 32'(busy), 32'(0));
    endtask

    // Main sequence: reset, table of frames, then multi-cycle corner cases.
    initial begin
        vec_t v;
        int   wv0;
        int   wr0;
        int   fe0;

        //            data          nb  ab  fA    fW1   expWord     val wr  b0     b1     fe ovf
        vecs[0] = '{32'h0000A55A, 24, 0,  1'b0, 1'b0, 24'h00A55A, 1, 2, 8'h5A, 8'hA5, 0, 1'b0};
        vecs[1] = '{32'h0003FF00, 24, 10, 1'b0, 1'b0, 24'h00A55A, 0, 0, 8'h00, 8'h00, 1, 1'b0};
        vecs[2] = '{32'h00001234, 24, 0,  1'b0, 1'b0, 24'h001234, 1, 2, 8'h34, 8'h12, 0, 1'b0};
        vecs[3] = '{32'h2AF37BED, 30, 0,  1'b0, 1'b0, 24'hABCDEF, 1, 2, 8'hEF, 8'hCD, 0, 1'b0};
        vecs[4] = '{32'h0000A55A, 24, 0,  1'b0, 1'b1, 24'h00A55A, 1, 1, 8'h5A, 8'h00, 0, 1'b1};
        vecs[5] = '{32'h000F0F0F, 24, 0,  1'b1, 1'b0, 24'h0F0F0F, 1, 0, 8'h00, 8'h00, 0, 1'b1};
        vecs[6] = '{32'h00123456, 24, 0,  1'b0, 1'b0, 24'h123456, 1, 2, 8'h56, 8'h34, 0, 1'b1};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkResetState("initial reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        for (int k = 0; k < NUM_VECS; k++) begin
            wv0 = wvCount;
            wr0 = wrCount;
            fe0 = feCount;
            applyStimulus(vecs[k]);
            checkVector($sformatf("vec%0d", k), vecs[k], wv0, wr0, fe0);
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        checkResetState("reset clears overflow");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Reset after 8 bits, the rest of the frame keeps arriving.
        wv0 = wvCount;
        wr0 = wrCount;
        nsync = 1'b0;
        repeat (8) @(negedge clk);
        sendBits(32'h000000A5, 8, 0, 1'b0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sendBits(32'h00005A5A, 16, 0, 1'b0);
        repeat (6) @(negedge clk);
        nsync = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("midreset word_valid count", 32'(wvCount - wv0), 32'(0));
        checkOutput("midreset write count", 32'(wrCount - wr0), 32'(0));
        checkOutput("midreset word", 32'(word), 32'(0));
        checkOutput("midreset busy", 32'(busy), 32'(0));

        v = '{32'h00654321, 24, 0, 1'b0, 1'b0, 24'h654321, 1, 2, 8'h21, 8'h43, 0, 1'b0};
        wv0 = wvCount;
        wr0 = wrCount;
        fe0 = feCount;
        applyStimulus(v);
        checkVector("after midreset", v, wv0, wr0, fe0);

        // nsync already low when reset is released must not start a frame.
        nsync = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wv0 = wvCount;
        wr0 = wrCount;
        repeat (4) @(negedge clk);
        sendBits(32'h00FFFFFF, 24, 0, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("nsync low at release busy", 32'(busy), 32'(0));
        nsync = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("nsync low at release word_valid count", 32'(wvCount - wv0), 32'(0));
        checkOutput("nsync low at release write count", 32'(wrCount - wr0), 32'(0));
        checkOutput("nsync low at release word", 32'(word), 32'(0));

        // enable low keeps the block idle through a whole frame.
        enable = 1'b0;
        v = '{32'h00111111, 24, 0, 1'b0, 1'b0, 24'h000000, 0, 0, 8'h00, 8'h00, 0, 1'b0};
        wv0 = wvCount;
        wr0 = wrCount;
        fe0 = feCount;
        applyStimulus(v);
        checkVector("enable low", v, wv0, wr0, fe0);
        enable = 1'b1;
        repeat (4) @(negedge clk);

        v = '{32'h00C3A5F0, 24, 0, 1'b0, 1'b0, 24'hC3A5F0, 1, 2, 8'hF0, 8'hA5, 0, 1'b0};
        wv0 = wvCount;
        wr0 = wrCount;
        fe0 = feCount;
        applyStimulus(v);
        checkVector("enable restored", v, wv0, wr0, fe0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
